uart_ctrl: RTL and testbench
============================

# uart_ctrl

Serial-port controller that sits on the device side of the CPU's `ext_uart_*` handshake. It is the responder to the MEM stage's UART accesses: it accepts `ext_uart_start` + `t_data` and shifts the byte out on `txd`, and it deserialises `rxd` into `r_data`, raising `ext_uart_ready` until the CPU pulses `ext_uart_clear`. Format is fixed 8N1, LSB first, one clock domain.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per bit period (50 MHz / 115200). Must be at least 4 and even.
- `WORD`, default 32, width of the data buses on the CPU side.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ext_uart_start`  in  1  transmit request; sampled only when `ext_uart_busy`=0.
- `t_data`  in  WORD  transmit data; bits [7:0] are sent, the upper bits are ignored.
- `ext_uart_busy`  out  1  transmitter occupied.
- `ext_uart_ready`  out  1  received byte valid in `r_data`.
- `ext_uart_clear`  in  1  consume the received byte.
- `r_data`  out  WORD  received byte, zero-extended.
- `txd`  out  1  serial output; idles high.
- `rxd`  in  1  serial input; asynchronous.
- `frame_err`  out  1  one-cycle pulse when a frame is received with a bad stop bit.
- `overrun`  out  1  one-cycle pulse when a received byte is dropped.

## Operation
- **TX FSM**: states are T_IDLE, T_START, T_DATA, T_STOP.
  - T_IDLE with `start`=1: latch `t_data[7:0]` and go to T_START.
  - Each state holds for `CLKS_PER_BIT` cycles. T_DATA repeats 8 times, sending bit 0 first.
  - At the end of T_STOP, return to T_IDLE.
  - `txd` values: 0 in T_START, data bit in T_DATA, 1 in T_STOP and T_IDLE.
  - `busy` is 1 in every state except T_IDLE.
  - `start` while busy is ignored. It is not queued.
- **RX front end**: `rxd` passes through a 2-flop synchroniser. A falling edge is detected from the synchronised value and the value one cycle older.
- **RX FSM**: states are R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE on a falling edge: go to R_START and load the timer with `CLKS_PER_BIT/2`.
  - At timer expiry in R_START: if the line is still 0, go to R_DATA. Otherwise it was a glitch; go back to R_IDLE with no other effect.
  - R_DATA samples once every `CLKS_PER_BIT` cycles, 8 times, shifting LSB first.
  - R_STOP samples once after `CLKS_PER_BIT` cycles, then returns to R_IDLE.
- **Stop-bit outcome**:
  - Stop bit = 1 and `ready`=0: load `r_data`, set `ready`.
  - Stop bit = 1 and `ready`=1: drop the new byte, keep the old byte, pulse `overrun`.
  - Stop bit = 0: drop the byte, pulse `frame_err`. `ready` and `r_data` are unchanged.
- **Clear**: `clear`=1 forces `ready` to 0 on the next edge. If a valid byte completes in the same cycle, the clear applies to the old byte: the new byte is loaded, `ready` stays 1 and no overrun is reported.
- TX and RX are fully independent. Loopback of `txd` to `rxd` must work.

## Timing
- **Reset values**: `txd`=1, `ext_uart_busy`=0, `ext_uart_ready`=0, `r_data`=0, `frame_err`=0, `overrun`=0. Both FSMs go to idle and all counters to 0.
- **Reset mid-frame**: the frame is abandoned. `txd` is 1 from the next cycle.
- **TX latency**: `start` sampled at edge k. `busy`=1 and `txd`=0 from k+1. `busy` falls at edge k+1+10·`CLKS_PER_BIT`. A new `start` can be accepted in the cycle `busy` reads 0.
- **RX latency**: stop-bit sample occurs about 2 + 9.5·`CLKS_PER_BIT` cycles after the `rxd` falling edge (the 2 is synchroniser delay). `ready`, `frame_err` and `overrun` update one edge after that sample.
- **Pulses**: `frame_err` and `overrun` are high for exactly one cycle.
- **Counters**: the bit timer is `$clog2(CLKS_PER_BIT)` bits wide and counts down to 0. The bit index is 3 bits and exits its state at 7; it does not wrap.

## Structure
- **Shared package** `uart_pkg`:
  - `UART_DATA_BITS`=8.
  - TX and RX state enums, 2-bit encoding.
- **Sub-module** `uart_bit_timer`: loadable down-counter with a `tick` output, instantiated once for TX and once for RX. The FSMs stay in `uart_ctrl`.

## Test plan
Use `CLKS_PER_BIT`=8 for simulation.
- **TX single byte**: `t_data`=0x0000_00A5 with `start` for 1 cycle → `txd` reads 0,1,0,1,0,0,1,0,1,1, 8 cycles per bit. `busy` is high for 80 cycles, then 0.
- **Start while busy**: second `start` with 0x3C at cycle 20 of a frame → ignored. Only 0xA5 appears on `txd`.
- **RX valid frame**: drive 0x5A, 8N1, on `rxd` → `ready`=1 and `r_data`=0x0000_005A. After `clear`, `ready`=0 next cycle.
- **RX errors**:
  - Stop bit = 0 → `frame_err` pulses once, `ready` stays 0.
  - 2-cycle low glitch on `rxd` → no state change.
- **Overrun and clear collision**:
  - Send 0x11 then 0x22 without a clear → `overrun` pulses, `r_data`=0x11.
  - Repeat with `clear` asserted in the 0x22 completion cycle → `r_data`=0x22, `ready`=1, no `overrun`.
- **Loopback and reset**:
  - Connect `txd` to `rxd` and send 0xFF and 0x00 → both received correctly.
  - Assert `rst` mid-frame → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the UART controller.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_ctrl_if.sv
// CPU-side ext_uart_* handshake bundle; the CPU is master, the UART is slave.
interface uart_ctrl_if #(
    parameter int WORD = 32
);
    logic            ext_uart_start;
    logic [WORD-1:0] t_data;
    logic            ext_uart_busy;
    logic            ext_uart_ready;
    logic            ext_uart_clear;
    logic [WORD-1:0] r_data;

    modport master (
        output ext_uart_start, t_data, ext_uart_clear,
        input  ext_uart_busy, ext_uart_ready, r_data
    );

    modport slave (
        input  ext_uart_start, t_data, ext_uart_clear,
        output ext_uart_busy, ext_uart_ready, r_data
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_bit_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/uart_ctrl.sv
// 8N1 UART responder for the CPU ext_uart_* handshake: independent TX and RX FSMs.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int WORD         = 32
) (
    input  logic        clk,
    input  logic        rst,
    uart_ctrl_if.slave  bus,
    output logic        txd,
    input  logic        rxd,
    output logic        frame_err,
    output logic        overrun
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]    LAST_IDX = 3'(UART_DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_e                   tx_state_q, tx_state_d;
    logic [UART_DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic [2:0]                  tx_idx_q, tx_idx_d;
    logic                        txd_q, txd_d;
    logic                        tx_load, tx_tick;

    uart_bit_timer #(.W(TW)) u_tx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (FULL_BIT),
        .tick     (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            T_IDLE: if (bus.ext_uart_start) begin
                tx_shift_d = bus.t_data[UART_DATA_BITS-1:0];
                tx_state_d = T_START;
                tx_load    = 1'b1;
            end
            T_START: if (tx_tick) begin
                tx_state_d = T_DATA;
                tx_idx_d   = 3'd0;
                tx_load    = 1'b1;
            end
            T_DATA: if (tx_tick) begin
                tx_load    = 1'b1;
                tx_shift_d = {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
                if (tx_idx_q == LAST_IDX) begin
                    tx_state_d = T_STOP;
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end
            T_STOP: if (tx_tick) begin
                tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase

        // txd is decoded from the next state so the line comes straight off a flop
        case (tx_state_d)
            T_START: txd_d = 1'b0;
            T_DATA:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            txd_q      <= txd_d;
        end
    end

    assign txd               = txd_q;
    assign bus.ext_uart_busy = (tx_state_q != T_IDLE);

    // ---------------- receiver ----------------
    logic                        rx_meta_q, rx_sync_q, rx_prev_q;
    logic                        rx_fall;
    rx_state_e                   rx_state_q, rx_state_d;
    logic [UART_DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [2:0]                  rx_idx_q, rx_idx_d;
    logic [UART_DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                        ready_q, ready_d;
    logic                        frame_err_q, frame_err_d;
    logic                        overrun_q, overrun_d;
    logic                        rx_load, rx_tick;
    logic [TW-1:0]               rx_load_val;

    uart_bit_timer #(.W(TW)) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .tick     (rx_tick)
    );

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_idx_d    = rx_idx_q;
        rdata_d     = rdata_q;
        ready_d     = ready_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        rx_load     = 1'b0;
        rx_load_val = FULL_BIT;

        if (bus.ext_uart_clear) begin
            ready_d = 1'b0;
        end

        case (rx_state_q)
            R_IDLE: if (rx_fall) begin
                rx_state_d  = R_START;
                rx_load     = 1'b1;
                rx_load_val = HALF_BIT;
            end
            R_START: if (rx_tick) begin
                if (!rx_sync_q) begin
                    rx_state_d = R_DATA;
                    rx_idx_d   = 3'd0;
                    rx_load    = 1'b1;
                end else begin
                    rx_state_d = R_IDLE;
                end
            end
            R_DATA: if (rx_tick) begin
                rx_load    = 1'b1;
                rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
                if (rx_idx_q == LAST_IDX) begin
                    rx_state_d = R_STOP;
                end else begin
                    rx_idx_d = rx_idx_q + 3'd1;
                end
            end
            R_STOP: if (rx_tick) begin
                rx_state_d = R_IDLE;
                // A clear in the completion cycle frees the slot for the new byte
                if (!rx_sync_q) begin
                    frame_err_d = 1'b1;
                end else if (ready_q && !bus.ext_uart_clear) begin
                    overrun_d = 1'b1;
                end else begin
                    rdata_d = rx_shift_q;
                    ready_d = 1'b1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= R_IDLE;
            rx_shift_q  <= '0;
            rx_idx_q    <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rxd;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_shift_q  <= rx_shift_d;
            rx_idx_q    <= rx_idx_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.ext_uart_ready = ready_q;
    assign bus.r_data         = WORD'(rdata_q);
    assign frame_err          = frame_err_q;
    assign overrun            = overrun_q;

    logic unused_tdata;
    assign unused_tdata = ^bus.t_data[WORD-1:UART_DATA_BITS];
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl against a frame-level behavioural model.
module tb_uart_ctrl;
    localparam int CPB   = 8;
    localparam int WORD  = 32;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_drv = 1'b1;
    logic loop_en = 1'b0;
    logic rxd_w, txd, frame_err, overrun;

    uart_ctrl_if #(.WORD(WORD)) bus ();

    assign rxd_w = loop_en ? txd : rxd_drv;

    uart_ctrl #(.CLKS_PER_BIT(CPB), .WORD(WORD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .txd       (txd),
        .rxd       (rxd_w),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int fe_seen = 0;
    int ov_seen = 0;

    // reference model of the receive side, at byte/frame granularity
    logic       m_ready = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_fe    = 0;
    int         m_ov    = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rx_state(input string tag);
        vectors++;
        if (bus.ext_uart_ready !== m_ready) begin
            errors++;
            $display("FAIL %s_ready: got %b want %b", tag, bus.ext_uart_ready, m_ready);
        end
        vectors++;
        if (bus.r_data !== {24'h0, m_data}) begin
            errors++;
            $display("FAIL %s_rdata: got %h want %h", tag, bus.r_data, {24'h0, m_data});
        end
        vectors++;
        if (fe_seen != m_fe) begin
            errors++;
            $display("FAIL %s_frame_err_pulses: got %0d want %0d", tag, fe_seen, m_fe);
        end
        vectors++;
        if (ov_seen != m_ov) begin
            errors++;
            $display("FAIL %s_overrun_pulses: got %0d want %0d", tag, ov_seen, m_ov);
        end
    endtask

    // Sends one byte with start; optionally pokes a second start mid-frame.
    task automatic tx_frame(input logic [7:0] d, input int inj_at, input logic [7:0] inj_d);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        @(negedge clk);
        bus.t_data      = $urandom();
        bus.t_data[7:0] = d;
        bus.ext_uart_start = 1'b1;
        @(negedge clk);
        bus.ext_uart_start = 1'b0;
        bus.t_data = $urandom();
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            bus.ext_uart_start = (i == inj_at);
            if (i == inj_at) bus.t_data = {24'h0, inj_d};
            vectors++;
            if (txd !== fr[i / CPB]) begin
                errors++;
                $display("FAIL tx_txd cycle %0d: got %b want %b", i, txd, fr[i / CPB]);
            end
            vectors++;
            if (bus.ext_uart_busy !== 1'b1) begin
                errors++;
                $display("FAIL tx_busy cycle %0d: got %b want 1", i, bus.ext_uart_busy);
            end
        end
        @(negedge clk);
        bus.ext_uart_start = 1'b0;
        vectors++;
        if (bus.ext_uart_busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL tx_end: got busy %b txd %b want busy 0 txd 1", bus.ext_uart_busy, txd);
        end
        tick(3);
        vectors++;
        if (bus.ext_uart_busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL tx_not_queued: got busy %b txd %b want busy 0 txd 1", bus.ext_uart_busy, txd);
        end
        $display("tx byte %h (extra start at %0d) sent", d, inj_at);
    endtask

    // Drives one 8N1 frame on rxd; clear_at selects a frame cycle for a 1-cycle clear.
    task automatic rx_frame(input logic [7:0] d, input logic stop, input int clear_at);
        logic [9:0] fr;
        logic       clr_hit;
        fr = {stop, d, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            rxd_drv = fr[c / CPB];
            bus.ext_uart_clear = (c == clear_at);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        bus.ext_uart_clear = 1'b0;
        clr_hit = (clear_at == FRAME - 1);
        if (clear_at >= 0 && !clr_hit) m_ready = 1'b0;
        if (!stop) begin
            m_fe++;
        end else if (m_ready && !clr_hit) begin
            m_ov++;
        end else begin
            m_data  = d;
            m_ready = 1'b1;
        end
        tick(4);
        check_rx_state("rx");
        $display("rx byte %h stop %0d clear_at %0d: ready %b r_data %h", d, stop, clear_at,
                 bus.ext_uart_ready, bus.r_data);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.ext_uart_clear = 1'b1;
        @(negedge clk);
        bus.ext_uart_clear = 1'b0;
        m_ready = 1'b0;
        vectors++;
        if (bus.ext_uart_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got %b want 0", bus.ext_uart_ready);
        end
        $display("clear: ready %b", bus.ext_uart_ready);
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (txd !== 1'b1 || bus.ext_uart_busy !== 1'b0 || bus.ext_uart_ready !== 1'b0 ||
            bus.r_data !== '0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: got txd %b busy %b ready %b r_data %h fe %b ov %b want 1 0 0 0 0 0",
                     tag, txd, bus.ext_uart_busy, bus.ext_uart_ready, bus.r_data, frame_err, overrun);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        check_reset_values("post_reset_idle");
        $display("reset: txd %b busy %b ready %b", txd, bus.ext_uart_busy, bus.ext_uart_ready);
    endtask

    task automatic test_tx_single();
        tx_frame(8'hA5, -1, 8'h00);
    endtask

    task automatic test_start_while_busy();
        tx_frame(8'hA5, 20, 8'h3C);
    endtask

    task automatic test_rx_valid();
        rx_frame(8'h5A, 1'b1, -1);
        do_clear();
    endtask

    task automatic test_rx_errors();
        rx_frame(8'h33, 1'b0, -1);
        @(negedge clk);
        rxd_drv = 1'b0;
        tick(2);
        rxd_drv = 1'b1;
        tick(4 * CPB);
        check_rx_state("glitch");
        $display("glitch: ready %b r_data %h", bus.ext_uart_ready, bus.r_data);
        rx_frame(8'hC3, 1'b1, -1);
        do_clear();
    endtask

    task automatic test_overrun_clear();
        rx_frame(8'h11, 1'b1, -1);
        rx_frame(8'h22, 1'b1, -1);
        do_clear();
        rx_frame(8'h11, 1'b1, -1);
        rx_frame(8'h22, 1'b1, FRAME - 1);
        do_clear();
    endtask

    task automatic test_loopback();
        logic [7:0] vals [2];
        int n;
        vals[0] = 8'hFF;
        vals[1] = 8'h00;
        loop_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.t_data = {24'h0, vals[k]};
            bus.ext_uart_start = 1'b1;
            @(negedge clk);
            bus.ext_uart_start = 1'b0;
            n = 0;
            while (bus.ext_uart_busy === 1'b1 && n < 4 * FRAME) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (n >= 4 * FRAME) begin
                errors++;
                $display("FAIL loopback_busy_timeout: got busy %b want 0", bus.ext_uart_busy);
            end
            tick(5);
            m_data  = vals[k];
            m_ready = 1'b1;
            check_rx_state("loopback");
            $display("loopback byte %h: ready %b r_data %h", vals[k], bus.ext_uart_ready, bus.r_data);
            do_clear();
        end
        loop_en = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       stop;
        int         clr;
        for (int k = 0; k < 6; k++) begin
            d    = 8'($urandom());
            stop = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 1) == 1) ? FRAME - 1 : -1;
            rx_frame(d, stop, clr);
        end
        for (int k = 0; k < 2; k++) begin
            tx_frame(8'($urandom()), -1, 8'h00);
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_frame(8'h96, 1'b1, FRAME - 1);
        @(negedge clk);
        bus.t_data = 32'h0000_00F0;
        bus.ext_uart_start = 1'b1;
        @(negedge clk);
        bus.ext_uart_start = 1'b0;
        tick(20);
        rxd_drv = 1'b0;
        tick(3 * CPB);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_frame");
        rxd_drv = 1'b1;
        m_ready = 1'b0;
        m_data  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        tick(3 * CPB);
        check_reset_values("after_mid_frame_reset");
        check_rx_state("after_reset");
        $display("reset mid-frame: txd %b busy %b ready %b", txd, bus.ext_uart_busy, bus.ext_uart_ready);
    endtask

    initial begin
        bus.ext_uart_start = 1'b0;
        bus.ext_uart_clear = 1'b0;
        bus.t_data         = '0;
        test_reset();
        test_tx_single();
        test_start_while_busy();
        test_rx_valid();
        test_rx_errors();
        test_overrun_clear();
        test_loopback();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
